// File: rtl/cgra_ldst_server.sv
// Shared scratchpad responder for the CGRA tile load/store ports.
// Round-robin arbitration of tile requests, one access per three cycles, with DMA preload writes.
module cgra_ldst_server #(
  parameter int unsigned NB_TILES   = 16,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MEM_AWIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NB_TILES-1:0]        Req_I,
  input  logic [NB_TILES-1:0]        Wen_I,
  input  logic [NB_TILES*32-1:0]     Addr_I,
  input  logic [NB_TILES*DWIDTH-1:0] Wdata_I,
  output logic [NB_TILES-1:0]        Grant_O,
  output logic [NB_TILES-1:0]        Valid_O,
  output logic [DWIDTH-1:0]          Rdata_O,
  output logic                       Err_O,
  input  logic                       DMA_Write_En,
  input  logic [MEM_AWIDTH-1:0]      DMA_Addr,
  input  logic [DWIDTH-1:0]          DMA_Data,
  output logic                       DMA_Ready_O
);

  localparam int unsigned TW    = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 1 << MEM_AWIDTH;

  typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

  state_t state, next_state;

  logic [AW-1:0]         addr_arr  [NB_TILES];
  logic [DWIDTH-1:0]     wdata_arr [NB_TILES];
  logic [DWIDTH-1:0]     mem       [DEPTH];

  logic [TW-1:0]         sel, last_grant, win, cand;
  logic                  sel_wen, found, latch;
  logic [AW-1:0]         sel_addr;
  logic [DWIDTH-1:0]     sel_wdata;
  logic [NB_TILES-1:0]   busy, busy_set, eligible;
  logic [NB_TILES-1:0]   grant_d, valid_d, grant_q, valid_q;
  logic [DWIDTH-1:0]     rdata_q;
  logic                  err_q, dma_ready_q;
  logic                  in_range;
  logic [MEM_AWIDTH-1:0] word_idx;
  logic                  mem_we;
  logic [MEM_AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0]     mem_wdata;
  logic                  unused_addr_lsb;

  // Flat tile buses split into per-tile words.
  always_comb begin
    for (int i = 0; i < int'(NB_TILES); i++) begin
      addr_arr[i]  = Addr_I[AW*i +: AW];
      wdata_arr[i] = Wdata_I[DWIDTH*i +: DWIDTH];
    end
  end

  assign eligible        = Req_I & ~busy;
  assign in_range        = (sel_addr[AW-1:MEM_AWIDTH+2] == '0);
  assign word_idx        = sel_addr[MEM_AWIDTH+1:2];
  assign unused_addr_lsb = ^sel_addr[1:0];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state, round-robin pick and single memory write port.
  always_comb begin
    next_state = state;
    win        = '0;
    cand       = '0;
    found      = 1'b0;
    latch      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    grant_d    = '0;
    valid_d    = '0;
    busy_set   = '0;

    for (int k = 1; k <= int'(NB_TILES); k++) begin
      cand = TW'((int'(last_grant) + k) % int'(NB_TILES));
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state)
      IDLE: begin
        if (DMA_Write_En) begin
          mem_we    = 1'b1;
          mem_waddr = DMA_Addr;
          mem_wdata = DMA_Data;
        end else if (found) begin
          latch        = 1'b1;
          grant_d[win] = 1'b1;
          next_state   = ACC;
        end
      end
      ACC: begin
        mem_we        = sel_wen && in_range;
        mem_waddr     = word_idx;
        mem_wdata     = sel_wdata;
        valid_d[sel]  = 1'b1;
        busy_set[sel] = 1'b1;
        next_state    = RSP;
      end
      RSP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latched request, response registers and sticky error.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel         <= '0;
      sel_wen     <= 1'b0;
      sel_addr    <= '0;
      sel_wdata   <= '0;
      last_grant  <= TW'(NB_TILES - 1);
      busy        <= '0;
      grant_q     <= '0;
      valid_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      dma_ready_q <= 1'b1;
    end else begin
      grant_q     <= grant_d;
      valid_q     <= valid_d;
      dma_ready_q <= (next_state == IDLE);
      // A dropped request always clears busy, even in the cycle it is set.
      busy        <= (busy | busy_set) & Req_I;
      if (latch) begin
        sel       <= win;
        sel_wen   <= Wen_I[win];
        sel_addr  <= addr_arr[win];
        sel_wdata <= wdata_arr[win];
      end
      if (state == ACC) begin
        last_grant <= sel;
        rdata_q    <= (!sel_wen && in_range) ? mem[word_idx] : '0;
        if (!in_range) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign Grant_O     = grant_q;
  assign Valid_O     = valid_q;
  assign Rdata_O     = rdata_q;
  assign Err_O       = err_q;
  assign DMA_Ready_O = dma_ready_q;

endmodule

// File: tb/tb_cgra_ldst_server.sv
// Directed bench for cgra_ldst_server: DMA preload, loads/stores, round-robin order,
// held requests, out-of-range errors and reset during an access.
module tb_cgra_ldst_server;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [15:0]   Req_I, Wen_I;
  logic [511:0]  Addr_I, Wdata_I;
  logic [15:0]   Grant_O, Valid_O;
  logic [31:0]   Rdata_O;
  logic          Err_O;
  logic          DMA_Write_En;
  logic [7:0]    DMA_Addr;
  logic [31:0]   DMA_Data;
  logic          DMA_Ready_O;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  cgra_ldst_server dut (
    .Clk(Clk), .Reset(Reset), .Req_I(Req_I), .Wen_I(Wen_I), .Addr_I(Addr_I),
    .Wdata_I(Wdata_I), .Grant_O(Grant_O), .Valid_O(Valid_O), .Rdata_O(Rdata_O),
    .Err_O(Err_O), .DMA_Write_En(DMA_Write_En), .DMA_Addr(DMA_Addr),
    .DMA_Data(DMA_Data), .DMA_Ready_O(DMA_Ready_O)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic dma_write(input logic [7:0] a, input logic [31:0] d);
    DMA_Write_En = 1'b1; DMA_Addr = a; DMA_Data = d;
    @(posedge Clk); #1;
    DMA_Write_En = 1'b0;
  endtask

  // Single-tile access started in an IDLE cycle; ends in the next IDLE cycle.
  task automatic access(input int t, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    logic [31:0] m;
    m = 32'(1) << t;
    Wen_I[t] = wen;
    Addr_I[32*t +: 32] = addr;
    Wdata_I[32*t +: 32] = wd;
    Req_I[t] = 1'b1;
    @(negedge Clk);
    check_eq({tag, "_ready"}, 32'(DMA_Ready_O), 32'd1);
    @(negedge Clk);
    check_eq({tag, "_grant"}, 32'(Grant_O), m);
    check_eq({tag, "_novalid"}, 32'(Valid_O), 32'd0);
    @(negedge Clk);
    check_eq({tag, "_valid"}, 32'(Valid_O), m);
    check_eq({tag, "_nogrant"}, 32'(Grant_O), 32'd0);
    check_eq({tag, "_rdata"}, Rdata_O, exp_rd);
    Req_I[t] = 1'b0;
    Wen_I[t] = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_gr, n_val, last_cyc, overlap, g;
    logic seen;
    Reset = 1'b0; Req_I = '0; Wen_I = '0; Addr_I = '0; Wdata_I = '0;
    DMA_Write_En = 1'b0; DMA_Addr = '0; DMA_Data = '0;
    repeat (2) @(negedge Clk);
    check_eq("rst_grant", 32'(Grant_O), 32'd0);
    check_eq("rst_valid", 32'(Valid_O), 32'd0);
    check_eq("rst_rdata", Rdata_O, 32'd0);
    check_eq("rst_err", 32'(Err_O), 32'd0);
    check_eq("rst_ready", 32'(DMA_Ready_O), 32'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;

    // DMA preload then tile 3 load of word 5.
    dma_write(8'd5, 32'hDEADBEEF);
    access(3, 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, "t3_load");

    // Store then load with ignored byte offset.
    access(0, 1'b1, 32'h08, 32'h12345678, 32'h0, "t0_store");
    access(0, 1'b0, 32'h0B, 32'h0, 32'h12345678, "t0_load");

    // All tiles at once from reset: order 0..15, one grant every 3 cycles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      Wen_I[i] = 1'b1;
      Addr_I[32*i +: 32] = 32'h100 + 32'(4*i);
      Wdata_I[32*i +: 32] = 32'hA000 + 32'(i);
    end
    Req_I = '1;
    n_gr = 0; n_val = 0; last_cyc = 0; overlap = 0;
    for (int c = 0; c < 120 && n_val < 16; c++) begin
      @(negedge Clk);
      if (Grant_O != 0 && Valid_O != 0) overlap++;
      if (Grant_O != 0) begin
        check_eq($sformatf("rr_grant%0d", n_gr), 32'(Grant_O), 32'(1) << n_gr);
        if (n_gr > 0) check_eq($sformatf("rr_gap%0d", n_gr), 32'(c - last_cyc), 32'd3);
        last_cyc = c;
        n_gr++;
      end
      if (Valid_O != 0) begin
        check_eq($sformatf("rr_valid%0d", n_val), 32'(Valid_O), 32'(1) << n_val);
        for (int j = 0; j < 16; j++) if (Valid_O[j]) Req_I[j] = 1'b0;
        n_val++;
      end
    end
    check_eq("rr_grant_count", 32'(n_gr), 32'd16);
    check_eq("rr_valid_count", 32'(n_val), 32'd16);
    check_eq("rr_overlap", 32'(overlap), 32'd0);
    Req_I = '0; Wen_I = '0;
    @(posedge Clk); #1;
    access(4, 1'b0, 32'h124, 32'h0, 32'hA009, "rr_readback");

    // Tile 2 holds its request after completion: no re-grant until it drops.
    Wen_I[2] = 1'b0; Addr_I[64 +: 32] = 32'h14; Req_I[2] = 1'b1;
    @(negedge Clk); @(negedge Clk);
    check_eq("hold_grant", 32'(Grant_O), 32'h4);
    @(negedge Clk);
    check_eq("hold_valid", 32'(Valid_O), 32'h4);
    check_eq("hold_rdata", Rdata_O, 32'hDEADBEEF);
    g = 0;
    repeat (10) begin
      @(negedge Clk);
      if (Grant_O != 0 || Valid_O != 0) g++;
    end
    check_eq("hold_no_regrant", 32'(g), 32'd0);
    Req_I[2] = 1'b0;
    @(posedge Clk); #1;
    Req_I[2] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge Clk);
      if (Grant_O[2]) seen = 1'b1;
    end
    check_eq("hold_regrant", 32'(seen), 32'd1);
    @(negedge Clk);
    check_eq("hold_revalid", 32'(Valid_O), 32'h4);
    Req_I[2] = 1'b0;
    @(posedge Clk); #1;

    // Out-of-range load and store.
    access(1, 1'b0, 32'h400, 32'h0, 32'h0, "oor_load");
    check_eq("oor_err_set", 32'(Err_O), 32'd1);
    access(1, 1'b1, 32'h408, 32'h00000BAD, 32'h0, "oor_store");
    access(0, 1'b0, 32'h08, 32'h0, 32'h12345678, "oor_mem_kept");
    check_eq("oor_err_sticky", 32'(Err_O), 32'd1);

    // DMA wins over tile 5, then reset during tile 5's access.
    DMA_Write_En = 1'b1; DMA_Addr = 8'd7; DMA_Data = 32'hCAFE0007;
    Wen_I[5] = 1'b0; Addr_I[160 +: 32] = 32'h1C; Req_I[5] = 1'b1;
    @(negedge Clk);
    check_eq("dma_ready", 32'(DMA_Ready_O), 32'd1);
    @(negedge Clk);
    check_eq("dma_first_nogrant", 32'(Grant_O), 32'd0);
    DMA_Write_En = 1'b0;
    @(negedge Clk);
    check_eq("dma_then_grant5", 32'(Grant_O), 32'h20);
    Reset = 1'b0;
    #1;
    check_eq("midrst_grant", 32'(Grant_O), 32'd0);
    check_eq("midrst_valid", 32'(Valid_O), 32'd0);
    check_eq("midrst_ready", 32'(DMA_Ready_O), 32'd1);
    check_eq("midrst_rdata", Rdata_O, 32'd0);
    check_eq("midrst_err", 32'(Err_O), 32'd0);
    Req_I[5] = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    g = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Grant_O != 0 || Valid_O != 0) g++;
    end
    check_eq("midrst_no_pulse", 32'(g), 32'd0);
    @(posedge Clk); #1;
    access(5, 1'b0, 32'h1C, 32'h0, 32'hCAFE0007, "dma_landed");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
